// File: rtl/cv32e40s_rf_scrubber.sv
// rtl/cv32e40s_rf_scrubber.sv - background ECC scrubber for the secure register file
// Walks x1..x(NUM_WORDS-1), writes back corrected words at lowest priority, reports errors.
module cv32e40s_rf_scrubber #(
    parameter int NUM_WORDS  = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int WORD_WIDTH = 38,
    parameter int INTERVAL   = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_i,
    input  logic                  core_we_i,
    input  logic [ADDR_WIDTH-1:0] core_waddr_i,
    output logic [ADDR_WIDTH-1:0] raddr_o,
    input  logic [WORD_WIDTH-1:0] dec_data_i,
    input  logic                  dec_err_single_i,
    input  logic                  dec_err_double_i,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [WORD_WIDTH-1:0] wdata_o,
    output logic                  err_corrected_o,
    output logic                  err_uncorrectable_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic                  busy_o,
    output logic                  sweep_done_o
);

    localparam int TIMER_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [TIMER_W-1:0]    TIMER_RELOAD = TIMER_W'(INTERVAL - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_FIRST    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST     = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    state_e                  state_q, state_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [WORD_WIDTH-1:0]   wbuf_q, wbuf_d;
    logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
    logic                    corr_q, corr_d;
    logic                    unc_q, unc_d;
    logic                    sweep_q, sweep_d;
    logic                    advance;
    logic                    core_hits_ptr;
    logic                    core_hits_waddr;

    assign core_hits_ptr   = core_we_i && (core_waddr_i == ptr_q);
    assign core_hits_waddr = core_we_i && (core_waddr_i == waddr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= TIMER_RELOAD;
            ptr_q      <= PTR_FIRST;
            waddr_q    <= '0;
            wbuf_q     <= '0;
            err_addr_q <= '0;
            corr_q     <= 1'b0;
            unc_q      <= 1'b0;
            sweep_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ptr_q      <= ptr_d;
            waddr_q    <= waddr_d;
            wbuf_q     <= wbuf_d;
            err_addr_q <= err_addr_d;
            corr_q     <= corr_d;
            unc_q      <= unc_d;
            sweep_q    <= sweep_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        ptr_d      = ptr_q;
        waddr_d    = waddr_q;
        wbuf_d     = wbuf_q;
        err_addr_d = err_addr_q;
        corr_d     = 1'b0;
        unc_d      = 1'b0;
        sweep_d    = 1'b0;
        advance    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    if (timer_q == '0) begin
                        state_d = READ;
                        timer_d = TIMER_RELOAD;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
            end
            READ: begin
                state_d = IDLE;
                timer_d = TIMER_RELOAD;
                // A core write to the word being read makes the decoder result stale.
                if (!enable_i) begin
                    advance = 1'b0;
                end else if (core_hits_ptr) begin
                    advance = 1'b1;
                end else if (dec_err_double_i) begin
                    unc_d      = 1'b1;
                    err_addr_d = ptr_q;
                    advance    = 1'b1;
                end else if (dec_err_single_i) begin
                    corr_d     = 1'b1;
                    err_addr_d = ptr_q;
                    waddr_d    = ptr_q;
                    wbuf_d     = dec_data_i;
                    state_d    = WRITE;
                end else begin
                    advance = 1'b1;
                end
            end
            WRITE: begin
                timer_d = TIMER_RELOAD;
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (!core_we_i || core_hits_waddr) begin
                    state_d = IDLE;
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (advance) begin
            ptr_d   = (ptr_q == PTR_LAST) ? PTR_FIRST : ptr_q + ADDR_WIDTH'(1);
            sweep_d = (ptr_q == PTR_LAST);
        end
    end

    always_comb begin
        we_o   = (state_q == WRITE) && !core_we_i && enable_i;
        busy_o = (state_q != IDLE);
    end

    assign raddr_o             = ptr_q;
    assign waddr_o             = waddr_q;
    assign wdata_o             = wbuf_q;
    assign err_corrected_o     = corr_q;
    assign err_uncorrectable_o = unc_q;
    assign err_addr_o          = err_addr_q;
    assign sweep_done_o        = sweep_q;

endmodule
